// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int PC_STEP    = 4;

  // Fetch controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // one cycle after reset before the first request
    REQ  = 2'd1,  // request outstanding, result will be used
    DROP = 2'd2,  // request outstanding, result is stale and will be discarded
    OUT  = 2'd3   // instruction held for decode
  } state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC and pending redirect target registers.
// Latency: loads/increments take effect on the next rising edge.
// Backpressure: none; the controller decides when to load, increment or hold.
// Ports: clk/reset (sync, active-high); load_fetch + fetch_target load the fetch PC;
//        inc_fetch advances it by PC_STEP (modulo 2^ADDR_W); load_pending + pending_in
//        capture a redirect target; fetch_pc/pending_target expose the registers.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_fetch,
  input  logic              inc_fetch,
  input  logic [ADDR_W-1:0] fetch_target,
  input  logic              load_pending,
  input  logic [ADDR_W-1:0] pending_in,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] pending_target
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pending_q, pending_d;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    // A load always beats an increment; the controller never asks for both.
    if (load_fetch) begin
      fetch_pc_d = fetch_target;
    end else if (inc_fetch) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end
    if (load_pending) begin
      pending_d = pending_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pending_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
    end
  end

  assign fetch_pc       = fetch_pc_q;
  assign pending_target = pending_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, requests words from instruction
//   memory (req/ack) and hands instruction+PC to decode (valid/ready).
// Latency: ack at edge t -> InstrValid from t+1; decode transfer at t -> next IMemReq from t+1.
// Backpressure: Stall or ~InstrReady hold the output registers; an outstanding memory
//   request is never withdrawn and redirects during it turn its data into a discard.
// Ports: Clk, Reset (sync, active-high); Stall, InstrReady from decode; BranchTaken /
//   BranchTarget redirect; IMemReq/IMemAddr/IMemAck/IMemData to instruction memory;
//   Instruction/PCResult/InstrValid to decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemAck,
  input  logic [31:0]       IMemData,
  output logic [31:0]       Instruction,
  output logic [ADDR_W-1:0] PCResult,
  output logic              InstrValid,
  input  logic              InstrReady
);

  state_t            state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_result_q, pc_result_d;
  logic              instr_valid_q, instr_valid_d;

  logic              pc_load, pc_inc, pend_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic [ADDR_W-1:0] fetch_pc, pending_target;
  logic [ADDR_W-1:0] br_target;
  logic              ack, xfer;

  // Word-aligned redirect target; the low two bits are not meaningful.
  assign br_target = {BranchTarget[ADDR_W-1:2], 2'b00};
  // An ack with no request outstanding is meaningless and is ignored.
  assign ack       = IMemAck & imem_req_q;
  assign xfer      = instr_valid_q & InstrReady & ~Stall;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (Clk),
    .reset          (Reset),
    .load_fetch     (pc_load),
    .inc_fetch      (pc_inc),
    .fetch_target   (pc_load_val),
    .load_pending   (pend_load),
    .pending_in     (br_target),
    .fetch_pc       (fetch_pc),
    .pending_target (pending_target)
  );

  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    pc_result_d   = pc_result_q;
    instr_valid_d = instr_valid_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    pend_load     = 1'b0;
    pc_load_val   = br_target;

    case (state_q)
      IDLE: begin
        state_d     = REQ;
        imem_req_d  = 1'b1;
        imem_addr_d = fetch_pc;
      end

      REQ: begin
        if (ack) begin
          if (BranchTaken) begin
            // Redirect lands with the data: drop the word and re-request at once.
            pc_load     = 1'b1;
            pc_load_val = br_target;
            imem_addr_d = br_target;
          end else begin
            instr_d       = IMemData;
            pc_result_d   = fetch_pc;
            instr_valid_d = 1'b1;
            pc_inc        = 1'b1;
            imem_req_d    = 1'b0;
            state_d       = OUT;
          end
        end else if (BranchTaken) begin
          // Request cannot be withdrawn; remember where to go once it completes.
          pend_load = 1'b1;
          state_d   = DROP;
        end
      end

      DROP: begin
        if (ack) begin
          pc_load     = 1'b1;
          pc_load_val = BranchTaken ? br_target : pending_target;
          imem_addr_d = pc_load_val;
          state_d     = REQ;
        end else if (BranchTaken) begin
          pend_load = 1'b1;
        end
      end

      OUT: begin
        if (BranchTaken) begin
          // Flush the held word whether or not decode is taking it this cycle.
          instr_valid_d = 1'b0;
          pc_load       = 1'b1;
          pc_load_val   = br_target;
          imem_req_d    = 1'b1;
          imem_addr_d   = br_target;
          state_d       = REQ;
        end else if (xfer) begin
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          imem_addr_d   = fetch_pc;
          state_d       = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_q       <= '0;
      pc_result_q   <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      pc_result_q   <= pc_result_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign IMemReq     = imem_req_q;
  assign IMemAddr    = imem_addr_q;
  assign Instruction = instr_q;
  assign PCResult    = pc_result_q;
  assign InstrValid  = instr_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed stimulus, queue-based scoreboard of decode transfers.
// A second instance with RESET_PC=32'hFFFF_FFFC checks PC wrap-around.
module tb_fetch_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset, Stall, BranchTaken, InstrReady;
  logic [31:0] BranchTarget;
  logic        IMemReq, IMemAck, InstrValid;
  logic [31:0] IMemAddr, IMemData, Instruction, PCResult;

  // memory model controls
  logic        man_mode, man_ack, auto_ack;
  logic [31:0] man_data, auto_data;
  int          mem_wait;
  int          mem_cnt;

  // second instance (wrap-around)
  logic        IMemReq2, IMemAck2, InstrValid2;
  logic [31:0] IMemAddr2, IMemData2, Instruction2, PCResult2;
  logic        zero_b = 1'b0;
  logic        one_b  = 1'b1;
  logic [31:0] zero_w = 32'h0;
  logic [31:0] exp2_pc    [2] = '{32'hFFFF_FFFC, 32'h0000_0000};
  logic [31:0] exp2_instr [2] = '{32'h1110_FFFC, 32'h1111_0000};
  int          idx2 = 0;

  int   n_checks = 0;
  int   n_errors = 0;
  int   xfer_cnt = 0;
  int   cyc_cnt  = 0;
  int   last_xfer_cyc = 0;
  int   prev_xfer_cyc = 0;
  int   k;
  exp_t exp_q[$];
  exp_t mon_e;

  initial forever #5 Clk = ~Clk;
  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  assign IMemAck   = man_mode ? man_ack  : auto_ack;
  assign IMemData  = man_mode ? man_data : auto_data;
  assign IMemAck2  = IMemReq2;
  assign IMemData2 = 32'h1111_0000 + IMemAddr2;

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemAck(IMemAck), .IMemData(IMemData), .Instruction(Instruction),
    .PCResult(PCResult), .InstrValid(InstrValid), .InstrReady(InstrReady)
  );

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .Clk(Clk), .Reset(Reset), .Stall(zero_b), .BranchTaken(zero_b),
    .BranchTarget(zero_w), .IMemReq(IMemReq2), .IMemAddr(IMemAddr2),
    .IMemAck(IMemAck2), .IMemData(IMemData2), .Instruction(Instruction2),
    .PCResult(PCResult2), .InstrValid(InstrValid2), .InstrReady(one_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic expect_x(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int w = 0;
    while (xfer_cnt < n && w < budget) begin
      cyc(1);
      w++;
    end
    check(name, 32'(xfer_cnt), 32'(n));
  endtask

  task automatic wait_valid(input int budget, input string name);
    int w = 0;
    while (!InstrValid && w < budget) begin
      cyc(1);
      w++;
    end
    check(name, {31'b0, InstrValid}, 32'h1);
  endtask

  // Memory model: acks mem_wait cycles after first seeing the request, one-cycle ack pulse.
  initial begin
    auto_ack  = 1'b0;
    auto_data = 32'hDEAD_DEAD;
    mem_cnt   = 0;
    forever begin
      @(posedge Clk);
      #1;
      if (auto_ack) begin
        auto_ack  = 1'b0;
        auto_data = 32'hDEAD_DEAD;
        mem_cnt   = 0;
      end else if (IMemReq) begin
        if (mem_cnt >= mem_wait) begin
          auto_ack  = 1'b1;
          auto_data = 32'h1111_0000 + IMemAddr;
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: a transfer happens at the next rising edge.
  initial forever begin
    @(negedge Clk);
    if (InstrValid && InstrReady && !Stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_xfer: got pc %h, expected no transfer", PCResult);
      end else begin
        mon_e = exp_q.pop_front();
        check("xfer_pc", PCResult, mon_e.pc);
        check("xfer_instr", Instruction, mon_e.instr);
      end
      xfer_cnt++;
      prev_xfer_cyc = last_xfer_cyc;
      last_xfer_cyc = cyc_cnt;
    end
  end

  initial forever begin
    @(negedge Clk);
    if (InstrValid2 && idx2 < 2) begin
      check("wrap_pc", PCResult2, exp2_pc[idx2]);
      check("wrap_instr", Instruction2, exp2_instr[idx2]);
      idx2++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
    InstrReady = 1'b1; man_mode = 1'b0; man_ack = 1'b0; man_data = 32'h0;
    mem_wait = 1;
    cyc(3);

    // reset state
    check("rst_req", {31'b0, IMemReq}, 32'h0);
    check("rst_addr", IMemAddr, 32'h0000_0000);
    check("rst_valid", {31'b0, InstrValid}, 32'h0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_pcresult", PCResult, 32'h0);
    check("rst_wrap_addr", IMemAddr2, 32'hFFFF_FFFC);
    check("rst_wrap_req", {31'b0, IMemReq2}, 32'h0);

    // sequential fetch with a one-cycle memory
    expect_x(32'h0000_0000, 32'h1111_0000);
    expect_x(32'h0000_0004, 32'h1111_0004);
    expect_x(32'h0000_0008, 32'h1111_0008);
    Reset = 1'b0;
    check("t1_req_before_edge", {31'b0, IMemReq}, 32'h0);
    cyc(1);
    check("t1_req_rise", {31'b0, IMemReq}, 32'h1);
    check("t1_addr", IMemAddr, 32'h0000_0000);
    wait_xfers(3, 40, "t1_xfers");
    check("t1_period", 32'(last_xfer_cyc - prev_xfer_cyc), 32'd3);
    InstrReady = 1'b0;

    // redirect while holding a word in OUT, decode stalled
    wait_valid(20, "t4_valid");
    check("t4_held_pc", PCResult, 32'h0000_000C);
    mem_wait = 3;
    Stall = 1'b1; InstrReady = 1'b1;
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0040;
    cyc(1);
    BranchTaken = 1'b0;
    check("t4_flush", {31'b0, InstrValid}, 32'h0);
    check("t4_req", {31'b0, IMemReq}, 32'h1);
    check("t4_addr", IMemAddr, 32'h0000_0040);
    expect_x(32'h0000_0040, 32'h1111_0040);

    // slow memory: address stable while waiting, then stall holds outputs
    k = 0;
    while (!InstrValid && k < 20) begin
      check("t2_addr_stable", IMemAddr, 32'h0000_0040);
      check("t2_req_held", {31'b0, IMemReq}, 32'h1);
      cyc(1);
      k++;
    end
    check("t2_valid", {31'b0, InstrValid}, 32'h1);
    repeat (4) begin
      cyc(1);
      check("t2_hold_valid", {31'b0, InstrValid}, 32'h1);
      check("t2_hold_pc", PCResult, 32'h0000_0040);
      check("t2_hold_instr", Instruction, 32'h1111_0040);
    end
    Stall = 1'b0;
    cyc(1);
    check("t2_one_xfer", 32'(xfer_cnt), 32'd4);

    // redirect while a request is outstanding: stale data dropped
    check("t3_req", {31'b0, IMemReq}, 32'h1);
    check("t3_addr_old", IMemAddr, 32'h0000_0044);
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0103;
    cyc(1);
    BranchTaken = 1'b0;
    check("t3_drop_req", {31'b0, IMemReq}, 32'h1);
    check("t3_drop_addr", IMemAddr, 32'h0000_0044);
    expect_x(32'h0000_0100, 32'h1111_0100);
    k = 0;
    while (IMemAddr == 32'h0000_0044 && k < 20) begin
      check("t3_no_valid", {31'b0, InstrValid}, 32'h0);
      cyc(1);
      k++;
    end
    check("t3_addr_new", IMemAddr, 32'h0000_0100);
    check("t3_req_new", {31'b0, IMemReq}, 32'h1);
    check("t3_valid_new", {31'b0, InstrValid}, 32'h0);
    wait_xfers(5, 30, "t3_xfers");
    InstrReady = 1'b0;

    // OUT redirect, then two more redirects during DROP: latest wins
    wait_valid(30, "t3b_valid");
    check("t3b_held_pc", PCResult, 32'h0000_0104);
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0300;
    cyc(1);
    check("t3b_addr1", IMemAddr, 32'h0000_0300);
    check("t3b_flush", {31'b0, InstrValid}, 32'h0);
    BranchTarget = 32'h0000_0400;
    cyc(1);
    check("t3b_addr_hold", IMemAddr, 32'h0000_0300);
    BranchTarget = 32'h0000_0502;
    cyc(1);
    BranchTaken = 1'b0;
    expect_x(32'h0000_0500, 32'h1111_0500);
    InstrReady = 1'b1;
    k = 0;
    while (IMemAddr == 32'h0000_0300 && k < 20) begin
      cyc(1);
      k++;
    end
    check("t3b_addr_latest", IMemAddr, 32'h0000_0500);
    wait_xfers(6, 30, "t3b_xfers");
    InstrReady = 1'b0;

    // reset while a request is outstanding, late ack afterwards
    man_mode = 1'b1; man_ack = 1'b0;
    cyc(2);
    check("t6_req_pending", {31'b0, IMemReq}, 32'h1);
    check("t6_addr_pending", IMemAddr, 32'h0000_0504);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0; man_ack = 1'b1; man_data = 32'hBAD0_BAD0;
    check("t6_req_reset", {31'b0, IMemReq}, 32'h0);
    check("t6_addr_reset", IMemAddr, 32'h0000_0000);
    check("t6_valid_reset", {31'b0, InstrValid}, 32'h0);
    cyc(1);
    man_ack = 1'b0;
    check("t6_req_restart", {31'b0, IMemReq}, 32'h1);
    check("t6_addr_restart", IMemAddr, 32'h0000_0000);
    check("t6_valid_restart", {31'b0, InstrValid}, 32'h0);
    expect_x(32'h0000_0000, 32'h1111_0000);
    man_mode = 1'b0; mem_wait = 1; InstrReady = 1'b1;
    wait_xfers(7, 30, "t6_xfers");
    InstrReady = 1'b0;
    cyc(3);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("wrap_xfers", 32'(idx2), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
